// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing master: scan counters, polarity-selectable syncs, data enable
// and line/frame strobes, all advancing only on the pixel-rate enable.
module vga_timing_gen #(
   parameter int WIDTH  = 640,
   parameter int H_FP   = 16,
   parameter int H_PW   = 96,
   parameter int H_BP   = 48,
   parameter int HEIGHT = 480,
   parameter int V_FP   = 10,
   parameter int V_PW   = 2,
   parameter int V_BP   = 33,
   parameter int HS_POL = 0,
   parameter int VS_POL = 0,
   parameter int CNT_W  = 10
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iPixEn,
   input  logic             iRun,
   output logic [CNT_W-1:0] oCountH,
   output logic [CNT_W-1:0] oCountV,
   output logic             oHS,
   output logic             oVS,
   output logic             oDE,
   output logic             oLineStart,
   output logic             oFrameStart,
   output logic             oIdle
);

   localparam int HTOT = WIDTH + H_FP + H_PW + H_BP;
   localparam int VTOT = HEIGHT + V_FP + V_PW + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOT - 1);
   localparam logic [CNT_W-1:0] H_ACTIVE = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] V_ACTIVE = CNT_W'(HEIGHT);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(WIDTH + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(WIDTH + H_FP + H_PW - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(HEIGHT + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(HEIGHT + V_FP + V_PW - 1);
   localparam logic             HS_LVL   = (HS_POL != 0);
   localparam logic             VS_LVL   = (VS_POL != 0);

   // Illegal parameter sets are rejected at elaboration rather than silently wrapping.
   if ((64'd1 << CNT_W) < 64'(HTOT) || (64'd1 << CNT_W) < 64'(VTOT)) begin : gCntWidthCheck
      $error("vga_timing_gen: CNT_W too small for HTOT/VTOT");
   end
   if (H_PW < 1 || V_PW < 1) begin : gPulseWidthCheck
      $error("vga_timing_gen: sync pulse widths must be non-zero");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } stateT;

   stateT            state;
   stateT            nextState;
   logic [1:0]       rstSync;
   logic             ready;
   logic [CNT_W-1:0] nextH;
   logic [CNT_W-1:0] nextV;
   logic             lineStart;
   logic             frameStart;
   logic             hsActive;
   logic             vsActive;
   logic             deNext;

   // Reset asserts asynchronously but releases through two flops, so the counters
   // never start on a metastable edge.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         rstSync <= 2'b00;
      end else begin
         rstSync <= {rstSync[0], 1'b1};
      end
   end

   assign ready = rstSync[1];

   // IDLE->RUN keeps (0,0) for the starting tick; a frame wrap with iRun low parks
   // silently instead of strobing.
   always_comb begin
      nextState  = state;
      nextH      = oCountH;
      nextV      = oCountV;
      lineStart  = 1'b0;
      frameStart = 1'b0;
      unique case (state)
         IDLE: begin
            if (ready && iPixEn && iRun) begin
               nextState  = RUN;
               lineStart  = 1'b1;
               frameStart = 1'b1;
            end
         end
         RUN: begin
            if (iPixEn) begin
               if (oCountH == H_LAST) begin
                  nextH = '0;
                  if (oCountV == V_LAST) begin
                     nextV = '0;
                     if (iRun) begin
                        lineStart  = 1'b1;
                        frameStart = 1'b1;
                     end else begin
                        nextState = IDLE;
                     end
                  end else begin
                     nextV     = oCountV + 1'b1;
                     lineStart = 1'b1;
                  end
               end else begin
                  nextH = oCountH + 1'b1;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Decoding from the next counts keeps syncs and DE aligned with the registered counters.
   always_comb begin
      hsActive = (nextH >= HS_FIRST) && (nextH <= HS_LAST);
      vsActive = (nextV >= VS_FIRST) && (nextV <= VS_LAST);
      deNext   = (nextH < H_ACTIVE) && (nextV < V_ACTIVE);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state       <= IDLE;
         oCountH     <= '0;
         oCountV     <= '0;
         oHS         <= ~HS_LVL;
         oVS         <= ~VS_LVL;
         oDE         <= 1'b1;
         oLineStart  <= 1'b0;
         oFrameStart <= 1'b0;
         oIdle       <= 1'b1;
      end else begin
         state       <= nextState;
         oCountH     <= nextH;
         oCountV     <= nextV;
         oHS         <= hsActive ? HS_LVL : ~HS_LVL;
         oVS         <= vsActive ? VS_LVL : ~VS_LVL;
         oDE         <= deNext;
         oLineStart  <= lineStart;
         oFrameStart <= frameStart;
         oIdle       <= (nextState == IDLE);
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed-polarity VGA timing counter. It generates horizontal and vertical scan counters, sync pulses with selectable polarity, a data-enable, and line/frame start strobes. It advances only on a pixel-rate enable, so it can run from a fast system clock. It sits between the clock/reset infrastructure and the pixel pipeline (framebuffer read, pattern generators), and it is the single timing master for the display path.

Parameters:
WIDTH, 640, active pixels per line
H_FP, 16, horizontal front porch (ticks)
H_PW, 96, horizontal sync pulse width (ticks)
H_BP, 48, horizontal back porch (ticks)
HEIGHT, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of oHS (0 = active-low)
VS_POL, 0, active level of oVS (0 = active-low)
CNT_W, 10, counter width; must satisfy 2^CNT_W >= max(HTOT, VTOT)

Ports:
iClk  in  1  system clock, rising edge
iRst_n  in  1  asynchronous, active-low reset
iPixEn  in  1  pixel tick; timing advances only when 1
iRun  in  1  1 = free-running; 0 = hold at frame start (0,0) after current frame ends
oCountH  out  CNT_W  horizontal position, 0..HTOT-1
oCountV  out  CNT_W  vertical position, 0..VTOT-1
oHS  out  1  horizontal sync, level per HS_POL
oVS  out  1  vertical sync, level per VS_POL
oDE  out  1  1 when oCountH<WIDTH and oCountV<HEIGHT
oLineStart  out  1  one-cycle strobe on the tick where oCountH becomes 0
oFrameStart  out  1  one-cycle strobe on the tick where (oCountH,oCountV) becomes (0,0)
oIdle  out  1  1 while parked at (0,0) with iRun=0

Behaviour:
- HTOT = WIDTH+H_FP+H_PW+H_BP (default 800); VTOT = HEIGHT+V_FP+V_PW+V_BP (default 525).
- All outputs are registered. oHS, oVS and oDE are decoded from the next count value, so they are always consistent with oCountH/oCountV in the same cycle. Latency from counter to decode is zero.
- Reset (iRst_n=0, asynchronous): oCountH=0, oCountV=0, oDE=1, oHS=!HS_POL, oVS=!VS_POL, oLineStart=0, oFrameStart=0, oIdle=1.
- Reset release is synchronised internally with a 2-flop deassertion. The first advance occurs on the first iPixEn=1 cycle after that.
- FSM states:
  - IDLE: counters held at (0,0), oIdle=1. Go to RUN on a cycle with iRun=1 and iPixEn=1. On that tick, oLineStart=1 and oFrameStart=1, and the counters stay at (0,0) for this tick. Position (0,0) is therefore displayed for one full tick.
  - RUN: on each iPixEn=1 cycle, H increments. When H=HTOT-1, H wraps to 0, V increments, and oLineStart pulses. When V=VTOT-1 and H=HTOT-1, both wrap to 0 and oFrameStart and oLineStart pulse.
  - At frame wrap with iRun=0, go to IDLE instead. The counters go to (0,0), oIdle=1, and no start strobes are issued.
- When iPixEn=0: counters, HS, VS and DE hold their values; strobes are 0. Strobes are never longer than one iClk cycle.
- HS active when WIDTH+H_FP <= H <= WIDTH+H_FP+H_PW-1 (default 656..751).
- VS active when HEIGHT+V_FP <= V <= HEIGHT+V_FP+V_PW-1 (default 490..491). VS changes only at line wrap, aligned with H=0.
- iRun=0 during a frame does not truncate it; the current frame completes. iRun toggling mid-frame has no effect until frame wrap.
- Asynchronous reset mid-frame forces the reset values immediately. No strobe is issued during or upon exit from reset except via the IDLE->RUN transition.
- Counter arithmetic is unsigned CNT_W. A parameter set that violates the CNT_W bound is an elaboration error (generate-time check). H_PW=0 or V_PW=0 is also illegal.

Test Plan:
- Defaults, iPixEn=1, iRun=1 after reset -> oFrameStart pulse at first tick; next oFrameStart exactly 420000 cycles later; oLineStart period 800 cycles.
- Defaults, HS_POL=0 -> oHS=0 exactly for oCountH 656..751 (96 ticks), 1 elsewhere; oVS=0 for oCountV 490..491 only (1600 ticks).
- HS_POL=1, VS_POL=1 -> sync pulses inverted at identical positions; reset levels oHS=0, oVS=0.
- iPixEn pulsed 1-in-4 -> all counter/sync transitions occur only on iPixEn cycles; frame period 1680000 cycles; strobes 1 cycle wide.
- iRun deasserted at V=100 -> frame completes to V=524,H=799, then counters park at (0,0) with oIdle=1 and no oFrameStart; reassert iRun -> oFrameStart on next iPixEn.
- iRst_n asserted at (H=300,V=200) mid-cycle -> outputs go to reset values without waiting for iClk; after release, IDLE->RUN restarts at (0,0).
